// File: rtl/uart_xmit_arbiter.sv
// rtl/uart_xmit_arbiter.sv - round-robin arbiter sharing one uart transmitter among byte requesters
//
// Purpose: grants the uart transmitter to one of NREQ requesters at a time in
// round-robin order, issues a one-cycle launch pulse, waits for the uart
// completion (or a watchdog abort), then holds an inter-byte gap.
//
// Ports:
//   sys_clk       clock, rising edge
//   sys_rst_l     asynchronous active-low reset
//   req_validH    per-requester byte pending
//   req_dataH     flattened request bytes, requester i at [i*DWIDTH +: DWIDTH]
//   req_ackH      one-hot pulse: requester's byte launched
//   req_doneH     one-hot pulse: requester's byte completed
//   xmitH         one-cycle launch pulse to the uart
//   xmit_dataH    byte to the uart, held from grant until the next grant
//   xmit_doneH    uart completion pulse
//   busyH         high whenever not idle
//   grant_idH     index of the current / last owner
//   timeout_errH  one-cycle pulse on watchdog abort

module uart_xmit_arbiter #(
  parameter int NREQ    = 4,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 4096,
  parameter int MIN_GAP = 1
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_l,
  input  logic [NREQ-1:0]           req_validH,
  input  logic [NREQ*DWIDTH-1:0]    req_dataH,
  output logic [NREQ-1:0]           req_ackH,
  output logic [NREQ-1:0]           req_doneH,
  output logic                      xmitH,
  output logic [DWIDTH-1:0]         xmit_dataH,
  input  logic                      xmit_doneH,
  output logic                      busyH,
  output logic [$clog2(NREQ)-1:0]   grant_idH,
  output logic                      timeout_errH
);

  localparam int GW  = $clog2(NREQ);
  localparam int WW  = $clog2(TIMEOUT);
  localparam int GPW = $clog2(MIN_GAP + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

  state_t          state;
  logic [GW-1:0]   lastGrant;
  logic [WW-1:0]   wdogCnt;
  logic [GPW-1:0]  gapCnt;

  logic            arbHit;
  logic [GW-1:0]   arbSel;
  logic [GW:0]     candSum;
  logic [GW-1:0]   candIdx;
  logic [DWIDTH-1:0] selData;

  // Scan candidates from farthest to nearest after lastGrant so the nearest
  // valid requester is the last assignment and therefore wins.
  always_comb begin
    arbHit  = 1'b0;
    arbSel  = '0;
    candSum = '0;
    candIdx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      candSum = {1'b0, lastGrant} + (GW+1)'(i);
      if (candSum >= (GW+1)'(NREQ))
        candSum = candSum - (GW+1)'(NREQ);
      candIdx = candSum[GW-1:0];
      if (req_validH[candIdx]) begin
        arbHit = 1'b1;
        arbSel = candIdx;
      end
    end
  end

  always_comb begin
    selData = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arbSel == GW'(i))
        selData = req_dataH[i*DWIDTH +: DWIDTH];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state        <= IDLE;
      lastGrant    <= GW'(NREQ - 1);
      wdogCnt      <= '0;
      gapCnt       <= '0;
      req_ackH     <= '0;
      req_doneH    <= '0;
      xmitH        <= 1'b0;
      xmit_dataH   <= '0;
      busyH        <= 1'b0;
      grant_idH    <= '0;
      timeout_errH <= 1'b0;
    end else begin
      // Pulse outputs default low; each is raised only on its transition.
      xmitH        <= 1'b0;
      req_ackH     <= '0;
      req_doneH    <= '0;
      timeout_errH <= 1'b0;
      case (state)
        IDLE: begin
          if (arbHit) begin
            state      <= LAUNCH;
            xmit_dataH <= selData;
            grant_idH  <= arbSel;
            lastGrant  <= arbSel;
            xmitH      <= 1'b1;
            req_ackH   <= NREQ'(1) << arbSel;
            busyH      <= 1'b1;
          end
        end
        LAUNCH: begin
          state   <= WAIT;
          wdogCnt <= '0;
        end
        WAIT: begin
          // Completion takes priority over a same-edge watchdog expiry.
          if (xmit_doneH) begin
            state     <= GAP;
            req_doneH <= NREQ'(1) << grant_idH;
            wdogCnt   <= '0;
            gapCnt    <= '0;
          end else if (wdogCnt == WW'(TIMEOUT - 1)) begin
            state        <= GAP;
            timeout_errH <= 1'b1;
            wdogCnt      <= '0;
            gapCnt       <= '0;
          end else begin
            wdogCnt <= wdogCnt + 1'b1;
          end
        end
        GAP: begin
          if (gapCnt == GPW'(MIN_GAP - 1)) begin
            state  <= IDLE;
            busyH  <= 1'b0;
            gapCnt <= '0;
          end else begin
            gapCnt <= gapCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_xmit_arbiter.sv
// tb/tb_uart_xmit_arbiter.sv - directed self-checking bench for uart_xmit_arbiter

module tb_uart_xmit_arbiter;

  logic        sys_clk;
  logic        sys_rst_l;
  logic [3:0]  req_validH;
  logic [31:0] req_dataH;
  logic [3:0]  req_ackH;
  logic [3:0]  req_doneH;
  logic        xmitH;
  logic [7:0]  xmit_dataH;
  logic        xmit_doneH;
  logic        busyH;
  logic [1:0]  grant_idH;
  logic        timeout_errH;

  int nCompared = 0;
  int nMismatched = 0;

  uart_xmit_arbiter #(
    .NREQ(4), .DWIDTH(8), .TIMEOUT(16), .MIN_GAP(1)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_l(sys_rst_l),
    .req_validH(req_validH),
    .req_dataH(req_dataH),
    .req_ackH(req_ackH),
    .req_doneH(req_doneH),
    .xmitH(xmitH),
    .xmit_dataH(xmit_dataH),
    .xmit_doneH(xmit_doneH),
    .busyH(busyH),
    .grant_idH(grant_idH),
    .timeout_errH(timeout_errH)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
  endtask

  function automatic logic [31:0] allOuts();
    return {12'd0, xmitH, busyH, timeout_errH, req_ackH, req_doneH, grant_idH, xmit_dataH};
  endfunction

  task automatic waitLaunch(input int id, input logic [7:0] data);
    int n;
    n = 0;
    while (xmitH !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checkVal("launch_seen", {31'd0, xmitH}, 32'd1);
    checkVal("launch_ack", {28'd0, req_ackH}, 32'd1 << id);
    checkVal("launch_gid", {30'd0, grant_idH}, id);
    checkVal("launch_data", {24'd0, xmit_dataH}, {24'd0, data});
  endtask

  initial begin
    int order[6];
    int xmitCount;
    order = '{0, 1, 2, 3, 0, 1};

    // Reset held with random inputs
    sys_rst_l  = 1'b0;
    req_validH = 4'($urandom);
    req_dataH  = $urandom;
    xmit_doneH = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkVal("rst_outs", allOuts(), 32'd0);
      req_validH = 4'($urandom);
      req_dataH  = $urandom;
      xmit_doneH = 1'($urandom);
    end
    req_validH = 4'b0;
    xmit_doneH = 1'b0;
    req_dataH  = 32'h00A5_0000;
    sys_rst_l  = 1'b1;
    step();
    checkVal("idle_busy", {31'd0, busyH}, 32'd0);

    // Single request from requester 2
    req_validH = 4'b0100;
    step();
    checkVal("t2_xmit", {31'd0, xmitH}, 32'd1);
    checkVal("t2_ack", {28'd0, req_ackH}, 32'h4);
    checkVal("t2_data", {24'd0, xmit_dataH}, 32'hA5);
    checkVal("t2_gid", {30'd0, grant_idH}, 32'd2);
    checkVal("t2_busy", {31'd0, busyH}, 32'd1);
    req_validH = 4'b0;
    step();
    checkVal("t2_xmit_low", {31'd0, xmitH}, 32'd0);
    checkVal("t2_ack_low", {28'd0, req_ackH}, 32'd0);
    repeat (9) step();
    xmit_doneH = 1'b1;
    step();
    xmit_doneH = 1'b0;
    checkVal("t2_done", {28'd0, req_doneH}, 32'h4);
    checkVal("t2_busy_gap", {31'd0, busyH}, 32'd1);
    checkVal("t2_noerr", {31'd0, timeout_errH}, 32'd0);
    step();
    checkVal("t2_done_low", {28'd0, req_doneH}, 32'd0);
    checkVal("t2_idle", {31'd0, busyH}, 32'd0);

    // Done ignored in IDLE and LAUNCH; data frozen after grant
    xmit_doneH = 1'b1;
    step();
    xmit_doneH = 1'b0;
    checkVal("t6_idle_done", {28'd0, req_doneH}, 32'd0);
    checkVal("t6_idle_busy", {31'd0, busyH}, 32'd0);
    req_dataH  = 32'h3C00_0000;
    req_validH = 4'b1000;
    step();
    checkVal("t6_gid", {30'd0, grant_idH}, 32'd3);
    checkVal("t6_xmit", {31'd0, xmitH}, 32'd1);
    xmit_doneH = 1'b1;
    req_validH = 4'b0;
    req_dataH  = 32'hFFFF_FFFF;
    step();
    xmit_doneH = 1'b0;
    checkVal("t6_launch_done", {28'd0, req_doneH}, 32'd0);
    checkVal("t6_data_held", {24'd0, xmit_dataH}, 32'h3C);
    for (int i = 0; i < 3; i++) begin
      step();
      checkVal("t6_still_wait", {27'd0, busyH, req_doneH}, 32'h10);
    end
    xmit_doneH = 1'b1;
    step();
    xmit_doneH = 1'b0;
    checkVal("t6_done", {28'd0, req_doneH}, 32'h8);
    checkVal("t6_data_held2", {24'd0, xmit_dataH}, 32'h3C);
    step();

    // Watchdog abort of requester 1, requester 2 pending
    req_dataH  = 32'h005A_7700;
    req_validH = 4'b0110;
    step();
    checkVal("t4_gid", {30'd0, grant_idH}, 32'd1);
    checkVal("t4_ack", {28'd0, req_ackH}, 32'h2);
    checkVal("t4_data", {24'd0, xmit_dataH}, 32'h77);
    req_validH = 4'b0100;
    for (int s = 1; s <= 17; s++) begin
      step();
      checkVal("t4_no_done", {28'd0, req_doneH}, 32'd0);
      if (s == 16) checkVal("t4_err_early", {31'd0, timeout_errH}, 32'd0);
    end
    checkVal("t4_err", {31'd0, timeout_errH}, 32'd1);
    step();
    checkVal("t4_err_low", {31'd0, timeout_errH}, 32'd0);
    checkVal("t4_idle", {31'd0, busyH}, 32'd0);
    step();
    checkVal("t4_next_xmit", {31'd0, xmitH}, 32'd1);
    checkVal("t4_next_gid", {30'd0, grant_idH}, 32'd2);
    checkVal("t4_next_data", {24'd0, xmit_dataH}, 32'h5A);
    req_validH = 4'b0;
    step();
    step();

    // Asynchronous reset mid-WAIT
    #2 sys_rst_l = 1'b0;
    #1 checkVal("async_rst", allOuts(), 32'd0);
    for (int i = 0; i < 2; i++) begin
      req_validH = 4'($urandom);
      req_dataH  = $urandom;
      xmit_doneH = 1'($urandom);
      step();
      checkVal("rst_hold", allOuts(), 32'd0);
    end
    req_validH = 4'hF;
    req_dataH  = 32'h1312_1110;
    xmit_doneH = 1'b0;
    @(negedge sys_clk);
    sys_rst_l = 1'b1;

    // Round-robin rotation with all requesters valid
    for (int t = 0; t < 6; t++) begin
      waitLaunch(order[t], 8'(8'h10 + order[t]));
      xmitCount = 0;
      for (int c = 0; c < 5; c++) begin
        step();
        xmitCount += int'(xmitH);
      end
      checkVal("rr_single_xmit", xmitCount, 32'd0);
      xmit_doneH = 1'b1;
      step();
      xmit_doneH = 1'b0;
      checkVal("rr_done", {28'd0, req_doneH}, 32'd1 << order[t]);
      checkVal("rr_done_gid", {30'd0, grant_idH}, order[t]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
